// File: rtl/acs_accumulator_if.sv
// rtl/acs_accumulator_if.sv - command/response bundle for acs_accumulator
interface acs_accumulator_if;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_op;
  logic [3:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] acc;
  logic       carry;
  logic       ovf;
  logic       zero;

  modport master (
    output in_valid, in_op, in_data, out_ready,
    input  in_ready, out_valid, acc, carry, ovf, zero
  );

  modport slave (
    input  in_valid, in_op, in_data, out_ready,
    output in_ready, out_valid, acc, carry, ovf, zero
  );
endinterface

// File: rtl/acs_accumulator.sv
// rtl/acs_accumulator.sv - registered 4-bit accumulator on the add/sub stage
// with valid/ready handshake, carry/overflow/zero flags and optional saturation.
module acs_accumulator #(
  parameter bit SAT_EN = 1'b0
) (
  input logic               clk,
  input logic               rst_n,
  acs_accumulator_if.slave  bus
);
  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_ADD   = 2'b01;
  localparam logic [1:0] OP_SUB   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t     r_state;
  state_t     w_next;
  logic       w_in_ready;
  logic       w_out_valid;
  logic       w_accept;

  logic [1:0] r_op;
  logic [3:0] r_operand;
  logic [3:0] r_acc;
  logic       r_carry;
  logic       r_ovf;
  logic       r_zero;

  logic       w_sel;
  logic [3:0] w_b;
  logic [4:0] w_sum;
  logic [3:0] w_raw;
  logic       w_raw_carry;
  logic       w_raw_ovf;
  logic [3:0] w_acc_new;
  logic       w_carry_new;
  logic       w_ovf_new;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_next = S_EXEC;
      end
      S_EXEC: w_next = S_RESP;
      S_RESP: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_accept = w_in_ready & bus.in_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op      <= OP_LOAD;
      r_operand <= 4'h0;
    end else if (w_accept) begin
      r_op      <= bus.in_op;
      r_operand <= bus.in_data;
    end
  end

  // Add/sub stage: SUB is acc + ~operand + 1, so carry-out means "no borrow".
  assign w_sel       = (r_op == OP_SUB);
  assign w_b         = w_sel ? ~r_operand : r_operand;
  assign w_sum       = {1'b0, r_acc} + {1'b0, w_b} + {4'b0000, w_sel};
  assign w_raw       = w_sum[3:0];
  assign w_raw_carry = w_sum[4];
  assign w_raw_ovf   = (r_acc[3] == w_b[3]) & (w_raw[3] != r_acc[3]);

  always_comb begin
    w_acc_new   = 4'h0;
    w_carry_new = 1'b0;
    w_ovf_new   = 1'b0;
    case (r_op)
      OP_LOAD:  w_acc_new = r_operand;
      OP_CLEAR: w_acc_new = 4'h0;
      default: begin
        w_carry_new = w_raw_carry;
        w_ovf_new   = w_raw_ovf;
        w_acc_new   = w_raw;
        // Flags keep describing the raw operation even when acc is clamped.
        if (SAT_EN) begin
          if ((r_op == OP_ADD) && w_raw_carry)  w_acc_new = 4'hF;
          if ((r_op == OP_SUB) && !w_raw_carry) w_acc_new = 4'h0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc   <= 4'h0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b1;
    end else if (r_state == S_EXEC) begin
      r_acc   <= w_acc_new;
      r_carry <= w_carry_new;
      r_ovf   <= w_ovf_new;
      r_zero  <= (w_acc_new == 4'h0);
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.acc       = r_acc;
  assign bus.carry     = r_carry;
  assign bus.ovf       = r_ovf;
  assign bus.zero      = r_zero;
endmodule

// File: doc/acs_accumulator.md
# acs_accumulator

Sequential 4-bit accumulator that sits directly downstream of the team's 4-bit adder-cum-subtractor stage. It consumes that stage's sum/difference and carry/borrow output and feeds the sum back as the next operand. It adds a valid/ready command interface, a registered accumulator, status flags and optional saturation. It is the first stateful consumer of the add/sub datapath and the building block for the upcoming small ALU.

## Interface
- SAT_EN, default 0: 1 = unsigned saturation on ADD carry-out or SUB borrow; 0 = wrap-around.
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  command present.
- in_ready  out  1  block can accept a command.
- in_op  in  2  command: 00 LOAD, 01 ADD, 10 SUB, 11 CLEAR.
- in_data  in  4  operand, unsigned or two's complement.
- out_valid  out  1  result of the last accepted command is available.
- out_ready  in  1  consumer accepts the result.
- acc  out  4  accumulator value.
- carry  out  1  carry/borrow output of the add/sub stage for the last ADD/SUB. For SUB, 1 = no borrow.
- ovf  out  1  signed (two's complement) overflow of the last ADD/SUB.
- zero  out  1  acc == 0.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE:** in_ready=1, out_valid=0. When in_valid & in_ready, capture in_op/in_data into op/operand registers and go to EXEC.
- **EXEC:** in_ready=0, out_valid=0. The add/sub stage computes acc ± operand, with sel=1 for SUB. At the clock edge, commit acc/carry/ovf/zero and go to RESP.
  - LOAD: acc=operand, carry=0, ovf=0.
  - CLEAR: acc=0, carry=0, ovf=0.
  - ADD: raw = acc + operand (mod 16); carry = bit 4 of the 5-bit sum; ovf = (acc[3]==operand[3]) & (raw[3]!=acc[3]).
  - SUB: raw = acc + ~operand + 1 (mod 16); carry = 1 if acc ≥ operand (unsigned); ovf = (acc[3]!=operand[3]) & (raw[3]!=acc[3]).
  - With SAT_EN=0: acc=raw.
  - With SAT_EN=1: an ADD with carry=1 sets acc=4'hF; a SUB with carry=0 sets acc=4'h0. Otherwise acc=raw. carry and ovf always reflect the unsaturated raw operation.
  - zero is computed from the committed acc value.
- **RESP:** out_valid=1, in_ready=0. acc/carry/ovf/zero are held stable. When out_ready=1, go to IDLE.
- in_valid outside IDLE is ignored. The command is not captured and there is no error flag.
- acc/carry/ovf/zero are registered. They change only at the EXEC→RESP edge or on reset.
- in_op/in_data are don't-care unless in_valid & in_ready.

## Timing
- Reset, on the rising edge with rst_n=0:
  - Go to IDLE.
  - acc=0, carry=0, ovf=0, zero=1, out_valid=0, in_ready=1.
  - Any captured command is discarded.
- Reset mid-operation (EXEC or RESP): same as above. No out_valid is produced for the aborted command.
- in_ready and out_valid are decoded from registered state only. There is no combinational path from in_valid or out_ready.
- Latency: command accepted at edge N → results visible and out_valid=1 after edge N+1 → back to IDLE after edge N+2 if out_ready=1.
- Throughput: one command per 3 cycles with in_valid and out_ready held high.
- Backpressure: RESP holds indefinitely while out_ready=0, with outputs stable.
- in_valid held high across the RESP→IDLE edge is accepted on the first cycle in IDLE.

## Test plan
- **Reset:** LOAD 4'h7, then assert rst_n=0 for 1 cycle while in EXEC → acc=0, zero=1, carry=0, ovf=0, out_valid=0, in_ready=1. No out_valid ever appears for the LOAD.
- **Add with signed overflow:** LOAD 4'h5, then ADD 4'h3 → acc=4'h8, carry=0, ovf=1, zero=0. out_valid rises 2 cycles after acceptance.
- **Add wrap and saturation:** LOAD 4'hF, then ADD 4'h1.
  - SAT_EN=0 → acc=4'h0, carry=1, ovf=0, zero=1.
  - SAT_EN=1 → acc=4'hF, carry=1, zero=0.
- **Subtract:** LOAD 4'h3, then SUB 4'h5.
  - SAT_EN=0 → acc=4'hE, carry=0, ovf=0.
  - SAT_EN=1 → acc=4'h0, zero=1.
  - LOAD 4'h5, then SUB 4'h5 → acc=0, carry=1, zero=1.
  - LOAD 4'h8, then SUB 4'h1 → acc=4'h7, ovf=1.
- **Backpressure:** in RESP, hold out_ready=0 for 4 cycles while driving in_valid=1 with ADD 4'h2 → out_valid stays 1, acc unchanged, in_ready=0, ADD not captured. Raise out_ready → IDLE next cycle, and the ADD is accepted there.
- **Streaming:** hold in_valid=1 and out_ready=1 with the sequence LOAD 1, ADD 1, ADD 1, CLEAR → acceptances exactly 3 cycles apart, acc = 1, 2, 3, 0, and out_valid is high for one cycle per command.
